// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic-light controller: light state encodings
// and the default phase timing constants.
package traffic_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'b000,
    ST_P1   = 3'b001,
    ST_P2   = 3'b010,
    ST_P3   = 3'b011,
    ST_P4   = 3'b100
  } light_state_e;

  localparam int unsigned TL_CW      = 8;
  localparam int unsigned TL_DUR_P1  = 20;
  localparam int unsigned TL_DUR_P2  = 3;
  localparam int unsigned TL_DUR_P3  = 15;
  localparam int unsigned TL_DUR_P4  = 2;
  localparam int unsigned NUM_PHASES = 4;

endpackage

// File: rtl/phase_timer_dur_regfile.sv
// Four programmable phase-duration registers with reset defaults, one write
// port and a combinational read port indexed by phase.
module dur_regfile
  import traffic_pkg::*;
#(
  parameter int unsigned CW = TL_CW,
  parameter int unsigned D1 = TL_DUR_P1,
  parameter int unsigned D2 = TL_DUR_P2,
  parameter int unsigned D3 = TL_DUR_P3,
  parameter int unsigned D4 = TL_DUR_P4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [1:0]    sel,
  input  logic [CW-1:0] wval,
  input  logic [1:0]    rsel,
  output logic [CW-1:0] rdata
);

  logic [CW-1:0] dur [NUM_PHASES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dur[0] <= CW'(D1);
      dur[1] <= CW'(D2);
      dur[2] <= CW'(D3);
      dur[3] <= CW'(D4);
    end else if (we) begin
      dur[sel] <= wval;
    end
  end

  assign rdata = dur[rsel];

endmodule

// File: rtl/phase_timer.sv
// Per-phase duration timer: counts 1 Hz ticks in the current light phase and
// emits a one-cycle expiry pulse plus the remaining-seconds count.
module phase_timer
  import traffic_pkg::*;
#(
  parameter int unsigned SIZE   = 3,
  parameter int unsigned CW     = TL_CW,
  parameter int unsigned DUR_P1 = TL_DUR_P1,
  parameter int unsigned DUR_P2 = TL_DUR_P2,
  parameter int unsigned DUR_P3 = TL_DUR_P3,
  parameter int unsigned DUR_P4 = TL_DUR_P4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            tick,
  input  logic [SIZE-1:0] state,
  input  logic            pause,
  input  logic            cfg_we,
  input  logic [1:0]      cfg_sel,
  input  logic [CW-1:0]   cfg_val,
  output logic            equal,
  output logic [CW-1:0]   remaining,
  output logic            active
);

  logic [SIZE-1:0] state_q;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   dur_cur;
  logic [CW-1:0]   dur_rd;
  logic [CW-1:0]   dur_new;
  logic [1:0]      rsel;
  logic            done;
  logic            entry;
  logic            phase_valid;
  logic            cur_valid;

  assign entry       = (state != state_q);
  assign phase_valid = (state >= SIZE'(ST_P1)) && (state <= SIZE'(ST_P4));
  assign cur_valid   = (state_q >= SIZE'(ST_P1)) && (state_q <= SIZE'(ST_P4));
  assign rsel        = 2'(state - SIZE'(1));
  // A programmed duration of zero still yields a one-tick phase.
  assign dur_new     = (dur_rd == '0) ? CW'(1) : dur_rd;
  assign active      = cur_valid;

  dur_regfile #(
    .CW (CW),
    .D1 (DUR_P1),
    .D2 (DUR_P2),
    .D3 (DUR_P3),
    .D4 (DUR_P4)
  ) u_regs (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (cfg_we),
    .sel   (cfg_sel),
    .wval  (cfg_val),
    .rsel  (rsel),
    .rdata (dur_rd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= '0;
      cnt       <= '0;
      dur_cur   <= '0;
      done      <= 1'b0;
      equal     <= 1'b0;
      remaining <= '0;
    end else begin
      state_q <= state;
      equal   <= 1'b0;
      if (entry) begin
        // Entry outranks a coincident tick; the read sees the pre-write value.
        cnt       <= '0;
        done      <= 1'b0;
        dur_cur   <= phase_valid ? dur_new : '0;
        remaining <= phase_valid ? dur_new : '0;
      end else if (!cur_valid) begin
        cnt       <= '0;
        done      <= 1'b0;
        remaining <= '0;
      end else if (!done && !pause && tick) begin
        if (cnt == dur_cur - CW'(1)) begin
          done      <= 1'b1;
          cnt       <= dur_cur;
          equal     <= 1'b1;
          remaining <= '0;
        end else begin
          cnt       <= cnt + CW'(1);
          remaining <= dur_cur - cnt - CW'(1);
        end
      end
    end
  end

endmodule
